id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

ID/EX pipeline register with built-in load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded control and operands from the ID stage on each clock edge. It presents them to the EX stage: ex_alu_op and ex_funct drive the ALU control unit directly. It inserts bubbles on load-use hazards, holds on downstream stall, clears on branch flush, and counts inserted load-use bubbles.

## Interface
- BUBBLE_CNT_W, 16, width of the saturating load-use bubble counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_alu_op  in  2  ALUOp from main control (00 add, 01 sub, 10 R-type, 11 immediate-op)
- id_funct  in  6  instruction bits [5:0]
- id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch  in  1 each  main-control bits
- id_npc  in  32  PC+4
- id_rd1, id_rd2  in  32  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- flush  in  1  taken branch resolved downstream; kill the ID/EX contents
- ex_stall  in  1  EX or later stage cannot accept; hold the register
- ex_valid  out  1  EX holds a real instruction
- ex_alu_op, ex_funct, ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch  out  widths as inputs  registered copies
- ex_npc, ex_rd1, ex_rd2, ex_imm  out  32  registered copies
- ex_rs, ex_rt, ex_rd  out  5  registered copies
- stall_upstream  out  1  combinational; PC and IF/ID must hold this cycle
- bubble_count  out  BUBBLE_CNT_W  number of load-use bubbles inserted, saturating

## Operation
- Load-use hazard, combinational: `load_use = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
  - The comparison is conservative: rt is always compared.
- stall_upstream = ~flush & (load_use | ex_stall).
- Register update on each rising edge uses fixed priority; the first true action applies:
  1. flush: clear all outputs to zero, including ex_valid.
  2. ex_stall: hold every output unchanged.
  3. load_use: insert a bubble.
     - Clear all outputs to zero.
     - Increment bubble_count.
  4. otherwise: load every ex_* from the matching id_*.
     - ex_valid <= id_valid.
     - If id_valid = 0, all other outputs are loaded as zero.
- A cleared entry has ex_alu_op = 00 and all write/read enables = 0, so it is a true no-op.
- bubble_count increments only in case 3.
  - It saturates at all-ones and never wraps.
  - A flush or stall never increments it.
- A flush in the same cycle as a load_use produces no bubble count, and stall_upstream is 0.
  - The younger instruction in ID is killed by the upstream flush path.

## Timing
- Latency: 1 cycle, from id_* sampled at edge N to ex_* visible after edge N.
- stall_upstream is valid in the same cycle as the hazard, before the edge. It depends only on current ex_* registers and id_* inputs, and on flush and ex_stall.
- A load-use stall lasts exactly one cycle.
  - After the bubble, ex_mem_read = 0, so load_use deasserts.
  - The held ID instruction loads on the next edge.
- Under ex_stall the register holds for as many cycles as ex_stall stays high; outputs are stable throughout.
- Reset, asynchronous on rst_n low: every output register, including bubble_count, goes to zero immediately.
  - stall_upstream then reads 0 unless ex_stall = 1.
- Deassertion of rst_n is synchronised externally; the first load occurs on the first edge with rst_n high.
- Reset mid-stall or mid-bubble discards the held entry; no partial state survives.

## Test plan
- Pass-through:
  - Stimulus: id_valid=1, id_alu_op=10, id_funct=100010, id_rd1=0x5, id_rd2=0x3, id_reg_write=1.
  - Required: after one edge, ex_alu_op=10, ex_funct=100010, ex_rd1=0x5, ex_reg_write=1, ex_valid=1, stall_upstream=0.
- Load-use bubble:
  - Stimulus: EX holds lw (ex_mem_read=1, ex_rt=8); ID presents id_rs=8.
  - Required: stall_upstream=1 before the edge; after the edge all ex_* = 0 and bubble_count=1.
  - Required: on the next edge the ID instruction loads and stall_upstream=0.
- Rt-zero exemption:
  - Stimulus: ex_mem_read=1, ex_rt=0, id_rs=0.
  - Required: stall_upstream=0, normal load, bubble_count unchanged.
- Stall hold:
  - Stimulus: ex_stall=1 for 3 cycles while the id_* inputs change each cycle.
  - Required: ex_* constant for 3 edges, stall_upstream=1, bubble_count unchanged.
- Flush priority:
  - Stimulus: flush=1 with ex_stall=1 and a load-use condition present.
  - Required: after the edge all outputs = 0, stall_upstream=0 during the flush cycle, bubble_count unchanged.
- Async reset and saturation:
  - Stimulus A: pulse rst_n low mid-cycle while ex_valid=1. Required: all outputs 0 immediately, without waiting for a clock edge.
  - Stimulus B: force 65536 load-use bubbles. Required: bubble_count reads 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register for the 5-stage MIPS pipeline.
//               Detects load-use hazards, inserts bubbles, holds on EX stall,
//               clears on branch flush and counts inserted load-use bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [1:0]              id_alu_op,
    input  logic [5:0]              id_funct,
    input  logic                    id_reg_dst,
    input  logic                    id_alu_src,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic                    id_mem_to_reg,
    input  logic                    id_reg_write,
    input  logic                    id_branch,
    input  logic [31:0]             id_npc,
    input  logic [31:0]             id_rd1,
    input  logic [31:0]             id_rd2,
    input  logic [31:0]             id_imm,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic [4:0]              id_rd,
    input  logic                    flush,
    input  logic                    ex_stall,
    output logic                    ex_valid,
    output logic [1:0]              ex_alu_op,
    output logic [5:0]              ex_funct,
    output logic                    ex_reg_dst,
    output logic                    ex_alu_src,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_mem_to_reg,
    output logic                    ex_reg_write,
    output logic                    ex_branch,
    output logic [31:0]             ex_npc,
    output logic [31:0]             ex_rd1,
    output logic [31:0]             ex_rd2,
    output logic [31:0]             ex_imm,
    output logic [4:0]              ex_rs,
    output logic [4:0]              ex_rt,
    output logic [4:0]              ex_rd,
    output logic                    stall_upstream,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

    // Everything carried from ID to EX except the valid flag
    typedef struct packed {
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic        branch;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    idex_t                   id_pkt;
    idex_t                   ex_q;
    idex_t                   ex_d;
    logic                    valid_q;
    logic                    valid_d;
    logic [BUBBLE_CNT_W-1:0] cnt_q;
    logic [BUBBLE_CNT_W-1:0] cnt_d;
    logic                    load_use;

    assign id_pkt = '{
        alu_op:     id_alu_op,
        funct:      id_funct,
        reg_dst:    id_reg_dst,
        alu_src:    id_alu_src,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        reg_write:  id_reg_write,
        branch:     id_branch,
        npc:        id_npc,
        rd1:        id_rd1,
        rd2:        id_rd2,
        imm:        id_imm,
        rs:         id_rs,
        rt:         id_rt,
        rd:         id_rd
    };

    // A load in EX whose destination is read by the instruction in ID.
    // rt is always compared even when the ID instruction does not read it;
    // this only costs an occasional unnecessary bubble. $zero never hazards.
    assign load_use = valid_q & ex_q.mem_read & (ex_q.rt != 5'd0) & id_valid &
                      ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

    // A flush kills the younger instruction in ID, so no hold is requested
    assign stall_upstream = ~flush & (load_use | ex_stall);

    // Next-state selection: flush > stall > load-use bubble > normal load
    always_comb begin
        valid_d = valid_q;
        ex_d    = ex_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ex_d    = '0;
        end else if (ex_stall) begin
            valid_d = valid_q;
            ex_d    = ex_q;
        end else if (load_use) begin
            valid_d = 1'b0;
            ex_d    = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            valid_d = id_valid;
            ex_d    = id_valid ? id_pkt : '0;
        end
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ex_q    <= ex_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct      = ex_q.funct;
    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_branch     = ex_q.branch;
    assign ex_npc        = ex_q.npc;
    assign ex_rd1        = ex_q.rd1;
    assign ex_rd2        = ex_q.rd2;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign bubble_count  = cnt_q;

endmodule
`default_nettype wire
